// File: rtl/cmsdk_ahb_simple_master.sv
// Single-outstanding AHB-Lite initiator: valid/ready command/response to SINGLE transfers.
// Optional data-phase wait-state watchdog enabled by CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN.
module cmsdk_ahb_simple_master #(
    parameter bit          BE             = 1'b0,
    parameter logic [3:0]  HPROT_VALUE    = 4'b0011,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy
`ifdef CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN
    ,
    output logic        timeout_irq
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  htrans_d;
    logic [31:0] haddr_d, hwdata_d, rsp_rdata_d, wlanes, rd_ext;
    logic        hwrite_d, rsp_err_d, cmd_ready_d, rsp_valid_d, busy_d;
    logic [2:0]  hsize_d;
    logic        accept, illegal, timed_out;
    logic [1:0]  byte_lane;
    logic        half_hi;

    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VALUE;
    assign HMASTLOCK = 1'b0;

    assign accept  = cmd_valid & cmd_ready;
    assign illegal = (cmd_size == 2'd3)
                   | ((cmd_size == 2'd1) & cmd_addr[0])
                   | ((cmd_size == 2'd2) & (|cmd_addr[1:0]));

    // Write data replicated across every lane the slave might sample
    always_comb begin
        case (cmd_size)
            2'd0:    wlanes = {4{cmd_wdata[7:0]}};
            2'd1:    wlanes = {2{cmd_wdata[15:0]}};
            default: wlanes = cmd_wdata;
        endcase
    end

    // Read lane extraction from the registered address/size of the open transfer
    always_comb begin
        byte_lane = HADDR[1:0] ^ {BE, BE};
        half_hi   = HADDR[1] ^ BE;
        case (HSIZE[1:0])
            2'd0:    rd_ext = {24'd0, HRDATA[{byte_lane, 3'b000} +: 8]};
            2'd1:    rd_ext = half_hi ? {16'd0, HRDATA[31:16]} : {16'd0, HRDATA[15:0]};
            default: rd_ext = HRDATA;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        htrans_d    = HTRANS;
        haddr_d     = HADDR;
        hwrite_d    = HWRITE;
        hsize_d     = HSIZE;
        hwdata_d    = HWDATA;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d  = ADDR;
                        htrans_d = TRANS_NONSEQ;
                        haddr_d  = cmd_addr;
                        hwrite_d = cmd_write;
                        hsize_d  = {1'b0, cmd_size};
                        hwdata_d = cmd_write ? wlanes : 32'd0;
                    end
                end
            end
            ADDR: begin
                if (HREADY) begin
                    state_d  = DATA;
                    htrans_d = TRANS_IDLE;
                end
            end
            DATA: begin
                if (HREADY) begin
                    state_d     = RESP;
                    rsp_err_d   = HRESP | timed_out;
                    rsp_rdata_d = (HWRITE || HRESP || timed_out) ? 32'd0 : rd_ext;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= IDLE;
            HTRANS    <= TRANS_IDLE;
            HADDR     <= 32'd0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'd0;
            HWDATA    <= 32'd0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            HTRANS    <= htrans_d;
            HADDR     <= haddr_d;
            HWRITE    <= hwrite_d;
            HSIZE     <= hsize_d;
            HWDATA    <= hwdata_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
        end
    end

`ifdef CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt, wait_cnt_d;
    logic          timed_out_d, irq_d;

    // Wait-state watchdog: saturates once tripped, transfer still waits for HREADY
    always_comb begin
        wait_cnt_d  = wait_cnt;
        timed_out_d = timed_out;
        irq_d       = timeout_irq;
        if (state_q == IDLE && accept) begin
            wait_cnt_d  = '0;
            timed_out_d = 1'b0;
            irq_d       = 1'b0;
        end else if ((state_q == ADDR || state_q == DATA) && !HREADY && !timed_out) begin
            wait_cnt_d = wait_cnt + CW'(1);
            if (wait_cnt_d == CW'(TIMEOUT_CYCLES)) begin
                timed_out_d = 1'b1;
                irq_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt    <= '0;
            timed_out   <= 1'b0;
            timeout_irq <= 1'b0;
        end else begin
            wait_cnt    <= wait_cnt_d;
            timed_out   <= timed_out_d;
            timeout_irq <= irq_d;
        end
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYCLES);
    assign timed_out      = 1'b0;
`endif

endmodule

// File: tb/tb_cmsdk_ahb_simple_master.sv
// Bench for cmsdk_ahb_simple_master: little- and big-endian instances share one stimulus,
// driven from a vector table plus hand-written reset and watchdog sequences.
module tb_cmsdk_ahb_simple_master;

`ifdef CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TO    = 4;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TO    = 256;
`endif

    logic        HCLK, HRESET;
    logic        cmd_valid, cmd_write, rsp_ready;
    logic [31:0] cmd_addr, cmd_wdata, HRDATA;
    logic [1:0]  cmd_size;
    logic        HREADY, HRESP;

    logic        cmd_ready, rsp_valid, rsp_err, HWRITE, HMASTLOCK, busy;
    logic [31:0] rsp_rdata, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    logic        be_cmd_ready_unused, be_rsp_valid_unused, be_rsp_err, be_hwrite_unused;
    logic        be_hmastlock_unused, be_busy_unused;
    logic [31:0] be_rsp_rdata, be_haddr_unused, be_hwdata_unused;
    logic [1:0]  be_htrans_unused;
    logic [2:0]  be_hsize_unused, be_hburst_unused;
    logic [3:0]  be_hprot_unused;
`ifdef CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN
    logic        timeout_irq, be_timeout_irq_unused;
`endif

    cmsdk_ahb_simple_master #(.BE(1'b0), .HPROT_VALUE(4'b0011), .TIMEOUT_CYCLES(TO)) u_le (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .busy(busy)
`ifdef CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN
        , .timeout_irq(timeout_irq)
`endif
    );

    cmsdk_ahb_simple_master #(.BE(1'b1), .HPROT_VALUE(4'b0011), .TIMEOUT_CYCLES(TO)) u_be (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(be_cmd_ready_unused), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(be_rsp_valid_unused), .rsp_ready(rsp_ready), .rsp_rdata(be_rsp_rdata),
        .rsp_err(be_rsp_err),
        .HADDR(be_haddr_unused), .HTRANS(be_htrans_unused), .HWRITE(be_hwrite_unused),
        .HSIZE(be_hsize_unused), .HBURST(be_hburst_unused), .HPROT(be_hprot_unused),
        .HMASTLOCK(be_hmastlock_unused), .HWDATA(be_hwdata_unused), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .busy(be_busy_unused)
`ifdef CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN
        , .timeout_irq(be_timeout_irq_unused)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        logic [31:0] hwdata;
        logic [31:0] rd_le;
        logic [31:0] rd_be;
        bit          illegal;
        int          aw;
        int          dw;
        bit          herr;
        int          rw;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] rdata_be;
        logic        err;
    } exp_t;

    localparam int NV = 15;
    vec_t tbl [NV];
    exp_t sb [$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_waiting();
        chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e, got;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_size  = v.size; cmd_wdata = v.wdata;
        HREADY = 1'b1; HRESP = 1'b0;
        e.err      = v.illegal | v.herr | (TO_EN && (v.aw + v.dw >= TO));
        e.rdata    = e.err ? 32'd0 : v.rd_le;
        e.rdata_be = e.err ? 32'd0 : v.rd_be;
        sb.push_back(e);
        step();
        cmd_valid = 1'b0; cmd_wdata = 32'($urandom);
        if (v.illegal) begin
            chk("htrans_illegal", 32'(HTRANS), 32'd0);
        end else begin
            chk("htrans_nonseq", 32'(HTRANS), 32'h2);
            chk("haddr", HADDR, v.addr);
            chk("hwrite", 32'(HWRITE), 32'(v.write));
            chk("hsize", 32'(HSIZE), 32'(v.size));
            chk_waiting();
            for (int i = 0; i < v.aw; i++) begin
                HREADY = 1'b0;
                step();
                chk("haddr_hold", HADDR, v.addr);
                chk("htrans_hold", 32'(HTRANS), 32'h2);
                chk_waiting();
            end
            HREADY = 1'b1;
            step();
            chk("htrans_idle", 32'(HTRANS), 32'd0);
            if (v.write) chk("hwdata", HWDATA, v.hwdata);
            chk_waiting();
            for (int i = 0; i < v.dw; i++) begin
                HREADY = 1'b0;
                HRESP  = v.herr && (i == v.dw - 1);
                HRDATA = 32'($urandom);
                step();
                if (v.write) chk("hwdata_hold", HWDATA, v.hwdata);
                chk_waiting();
            end
            HREADY = 1'b1; HRESP = v.herr; HRDATA = v.hrdata;
            step();
            HRESP = 1'b0; HRDATA = 32'($urandom);
        end
        for (int i = 0; i < v.rw; i++) begin
            chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
            chk("cmd_ready_hold", 32'(cmd_ready), 32'd0);
            chk("htrans_quiet", 32'(HTRANS), 32'd0);
            HRDATA = 32'($urandom);
            step();
        end
        rsp_ready = 1'b1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        if (rsp_valid && sb.size() > 0) begin
            got = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, got.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(got.err));
            chk("rsp_rdata_be", be_rsp_rdata, got.rdata_be);
            chk("rsp_err_be", 32'(be_rsp_err), 32'(got.err));
        end
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        //          wr    addr          sz    wdata          hrdata         hwdata         rd_le          rd_be          ill aw dw err rw
        tbl[0]  = '{1'b1, 32'h0000_0004, 2'd2, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 32'h0000_0002, 2'd0, 32'h0,        32'h11223344, 32'h0,        32'h22,       32'h33,       0, 0, 0, 0, 0};
        tbl[2]  = '{1'b0, 32'h0000_0013, 2'd0, 32'h0,        32'h11223344, 32'h0,        32'h11,       32'h44,       0, 0, 0, 0, 2};
        tbl[3]  = '{1'b0, 32'h0000_0002, 2'd1, 32'h0,        32'h11223344, 32'h0,        32'h1122,     32'h3344,     0, 0, 0, 0, 0};
        tbl[4]  = '{1'b0, 32'h0000_0020, 2'd1, 32'h0,        32'hA1B2C3D4, 32'h0,        32'hC3D4,     32'hA1B2,     0, 0, 0, 0, 0};
        tbl[5]  = '{1'b0, 32'h0000_0008, 2'd2, 32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 0, 0};
        tbl[6]  = '{1'b1, 32'h0000_0001, 2'd0, 32'h123456A5, 32'h0,        32'hA5A5A5A5, 32'h0,        32'h0,        0, 0, 0, 0, 0};
        tbl[7]  = '{1'b1, 32'h0000_0002, 2'd1, 32'hFFFF1234, 32'h0,        32'h12341234, 32'h0,        32'h0,        0, 0, 0, 0, 0};
        tbl[8]  = '{1'b1, 32'h0000_0100, 2'd2, 32'h5A5A0F0F, 32'h0,        32'h5A5A0F0F, 32'h0,        32'h0,        0, 2, 3, 0, 0};
        tbl[9]  = '{1'b0, 32'h0000_0030, 2'd2, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        0, 0, 1, 1, 0};
        tbl[10] = '{1'b0, 32'h0000_000C, 2'd2, 32'h0,        32'h87654321, 32'h0,        32'h87654321, 32'h87654321, 0, 1, 0, 0, 0};
        tbl[11] = '{1'b0, 32'h0000_0006, 2'd2, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 5};
        tbl[12] = '{1'b1, 32'h0000_0000, 2'd3, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 0};
        tbl[13] = '{1'b0, 32'h0000_0001, 2'd1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 0};
        tbl[14] = '{1'b0, 32'h0000_0007, 2'd0, 32'h0,        32'h99887766, 32'h0,        32'h99,       32'h66,       0, 0, 2, 0, 0};

        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_size = 2'd0; cmd_wdata = 32'd0; rsp_ready = 1'b0;
        HRDATA = 32'd0; HREADY = 1'b1; HRESP = 1'b0;
        step(); step();
        HRESET = 1'b0;
        step();

        // Reset state
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("hburst", 32'(HBURST), 32'd0);
        chk("hprot", 32'(HPROT), 32'h3);
        chk("hmastlock", 32'(HMASTLOCK), 32'd0);
`ifdef CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN
        chk("rst_timeout_irq", 32'(timeout_irq), 32'd0);
`endif

        for (int i = 0; i < NV; i++) run_txn(tbl[i]);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Reset while the address phase is stalled abandons the transfer
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_size = 2'd2;
        step();
        cmd_valid = 1'b0;
        chk("mid_htrans_nonseq", 32'(HTRANS), 32'h2);
        HREADY = 1'b0; HRESET = 1'b1;
        step();
        HRESET = 1'b0; HREADY = 1'b1;
        chk("mid_rst_htrans", 32'(HTRANS), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("mid_rst_stays_idle", 32'(HTRANS), 32'd0);
        run_txn(tbl[5]);

`ifdef CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN
        // Watchdog trips on the 4th data-phase wait and clears on the next accept
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; cmd_size = 2'd2;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 1; i <= 6; i++) begin
            HREADY = 1'b0;
            step();
            chk("timeout_irq_ramp", 32'(timeout_irq), 32'(i >= 4));
            chk_waiting();
        end
        HREADY = 1'b1; HRDATA = 32'h12345678;
        step();
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("to_irq_sticky", 32'(timeout_irq), 32'd1);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        chk("to_irq_cleared", 32'(timeout_irq), 32'd0);
        step();
        chk("to_next_ok_valid", 32'(rsp_valid), 32'd1);
        chk("to_next_ok_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("to_done_idle", 32'(busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cmsdk_ahb_simple_master.md
Name: cmsdk_ahb_simple_master

Overview:
- Single-outstanding AHB-Lite initiator. It converts a simple valid/ready command/response interface into AHB-Lite SINGLE transfers.
- It is the initiator counterpart to the AHB slave peripherals (GPIO, timers, UART). Typical uses: a DMA-lite engine, a debug bridge, or bench stimulus driving those slaves.
- It handles lane alignment, wait states, and error responses, and returns read data LSB-aligned.

Parameters:
- BE, 0, 0 = little-endian lane mapping; 1 = byte-invariant big-endian (lane index XOR 3 for byte, XOR 2 for halfword).
- HPROT_VALUE, 4'b0011, constant HPROT driven on every transfer (data access, privileged).
- TIMEOUT_CYCLES, 256, data-phase wait-state limit; used only with the optional feature.

Ports:
- HCLK  in  1  single clock.
- HRESET  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- cmd_wdata  in  32  write data, LSB-aligned.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data, LSB-aligned, zero-extended; 0 for writes.
- rsp_err  out  1  bus error, misaligned address, or illegal size.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  {1'b0, cmd_size}.
- HBURST  out  3  constant 000 (SINGLE).
- HPROT  out  4  HPROT_VALUE.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  lane-replicated write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  global HREADY (from slave mux).
- HRESP  in  1  AHB response.
- busy  out  1  high when state != IDLE.

Behaviour:
- All outputs are registered.
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept with a legal command: register address, direction, and size; drive HTRANS=NONSEQ next cycle; go to ADDR.
  - On accept with an illegal command (size=3; size=1 with addr[0]!=0; size=2 with addr[1:0]!=0): no bus transfer; go to RESP with rsp_err=1 and rsp_rdata=0.
- ADDR:
  - HTRANS=NONSEQ, HADDR/HWRITE/HSIZE held stable.
  - HREADY=0: stay in ADDR, outputs unchanged.
  - HREADY=1: go to DATA; HTRANS=IDLE from the next cycle; HWDATA driven and held for the whole data phase.
- DATA:
  - HREADY=0: stay. HRESP=1 with HREADY=0 is the first error cycle; stay.
  - HREADY=1: capture rsp_err=HRESP. For a read, capture lane-extracted HRDATA.
  - Then go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held until rsp_ready=1.
  - On rsp_ready=1: go to IDLE; rsp_valid drops the next cycle.
  - cmd_ready=0 in every state except IDLE.
- Write lanes: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Read extraction:
  - Byte lane index = addr[1:0] (XOR 3 if BE).
  - Halfword lane index = addr[1] (inverted if BE).
  - Result zero-extended.
- Minimum latency, accept to rsp_valid, with zero wait states: 3 cycles.
- Error response: rsp_err=1 on a read forces rsp_rdata=0.
- Reset mid-transfer: synchronous return to IDLE and HTRANS=IDLE. The open transfer is abandoned; the system resets the slaves together with the master.
- Illegal commands never appear on the bus; HTRANS stays 00.

Optional Feature:
- Macro: CMSDK_AHB_SIMPLE_MASTER_TIMEOUT_EN.
- With the macro:
  - Adds output timeout_irq (1 bit) and a wait-state counter, width clog2(TIMEOUT_CYCLES+1).
  - The counter clears on entry to ADDR and counts every HREADY=0 cycle in ADDR or DATA.
  - On reaching TIMEOUT_CYCLES, timeout_irq sets sticky. The transfer still waits for HREADY, keeping the protocol legal.
  - When the response is delivered, rsp_err=1 even if HRESP=0.
  - timeout_irq clears only on HRESET or on the next accepted command.
- Without the macro: no counter, no timeout_irq port.

Test Plan:
- Word write: addr 0x0000_0004, data 0xDEADBEEF, HREADY=1 → one NONSEQ cycle with HSIZE=010 and HWRITE=1; HWDATA=0xDEADBEEF in the data phase; rsp_valid 3 cycles after accept; rsp_err=0.
- Byte read: addr 0x...0002, BE=0, HRDATA=0x11223344 → rsp_rdata=0x00000022. With BE=1 → rsp_rdata=0x00000033.
- Wait states: HREADY low 2 cycles in the address phase and 3 in the data phase → HADDR and HWDATA stable throughout; rsp_valid at accept+8.
- Error: slave drives HRESP=1/HREADY=0, then HRESP=1/HREADY=1 → rsp_err=1, rsp_rdata=0; next command accepted normally.
- Misaligned: size=2, addr 0x...0006 → HTRANS stays 00; rsp_err=1 after 1 cycle. Also: rsp_ready held low 5 cycles → rsp_valid held and cmd_ready=0 throughout.
- Timeout (macro on, TIMEOUT_CYCLES=4): HREADY held low 6 data-phase cycles → timeout_irq=1 after the 4th wait cycle; rsp_err=1 on completion; timeout_irq cleared by the next accepted command.
